acc_rd_sequencer: RTL and testbench

ACC_RD_SEQUENCER -- requirements
Module: acc_rd_sequencer

---
 rtl/acc_rd_sequencer.sv | 145 ++++++++++++++
 tb/tb_acc_rd_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_rd_sequencer.sv
// rtl/acc_rd_sequencer.sv - accumulator read sequencer issuing NORMAL or DIAG (skewed) row sweeps
// Optional abort input is compiled in when ACC_RD_ABORT_EN is defined.
module acc_rd_sequencer #(
  parameter int MUL_SIZE = 32,
  parameter int ADDR_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       start_mode,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [ADDR_W-1:0]          num_rows,
  input  logic                       stall,
`ifdef ACC_RD_ABORT_EN
  input  logic                       abort,
`endif
  output logic                       busy,
  output logic                       done,
  output logic [MUL_SIZE-1:0]        rd_en,
  output logic [MUL_SIZE*ADDR_W-1:0] rd_addr
);

  localparam int CNT_W = ADDR_W + $clog2(MUL_SIZE) + 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           t;
  logic [CNT_W-1:0]           total;
  logic                       cfg_mode;
  logic [ADDR_W-1:0]          cfg_base;
  logic [ADDR_W-1:0]          cfg_rows;
  logic                       eff_mode;
  logic [ADDR_W-1:0]          eff_base;
  logic [ADDR_W-1:0]          eff_rows;
  logic [CNT_W-1:0]           eff_rows_ext;
  logic [MUL_SIZE-1:0]        lane_en;
  logic [MUL_SIZE*ADDR_W-1:0] lane_addr;
  logic [CNT_W-1:0]           diff;
  logic                       abort_i;
  logic                       load_cfg;
  logic                       issue;
  logic                       clr_t;

`ifdef ACC_RD_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // Step 0 is issued on the accepting edge, so IDLE uses the live config inputs.
  assign eff_mode     = (state == IDLE) ? start_mode : cfg_mode;
  assign eff_base     = (state == IDLE) ? base_addr  : cfg_base;
  assign eff_rows     = (state == IDLE) ? num_rows   : cfg_rows;
  assign eff_rows_ext = CNT_W'({eff_rows == '0, eff_rows});
  assign total        = eff_mode ? (eff_rows_ext + CNT_W'(MUL_SIZE - 1)) : eff_rows_ext;

  always_comb begin
    lane_en   = '0;
    lane_addr = '0;
    diff      = '0;
    for (int c = 0; c < MUL_SIZE; c++) begin
      if (!eff_mode) begin
        lane_en[c]                    = 1'b1;
        lane_addr[c*ADDR_W +: ADDR_W] = eff_base + t[ADDR_W-1:0];
      end else if (t >= CNT_W'(c)) begin
        diff = t - CNT_W'(c);
        if (diff < eff_rows_ext) begin
          lane_en[c]                    = 1'b1;
          lane_addr[c*ADDR_W +: ADDR_W] = eff_base + diff[ADDR_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_cfg  = 1'b0;
    issue     = 1'b0;
    clr_t     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          load_cfg  = 1'b1;
          issue     = 1'b1;
        end
      end
      RUN: begin
        // Abort outranks stall; once every step is out, the sweep ends even if stalled.
        if (abort_i || (t == total)) begin
          state_nxt = DONE;
          clr_t     = 1'b1;
        end else if (!stall) begin
          issue = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t        <= '0;
      cfg_mode <= 1'b0;
      cfg_base <= '0;
      cfg_rows <= '0;
      rd_en    <= '0;
      rd_addr  <= '0;
    end else begin
      if (load_cfg) begin
        cfg_mode <= start_mode;
        cfg_base <= base_addr;
        cfg_rows <= num_rows;
      end
      if (issue) begin
        rd_en   <= lane_en;
        rd_addr <= lane_addr;
        t       <= t + CNT_W'(1);
      end else begin
        rd_en <= '0;
        if (clr_t) begin
          t <= '0;
        end
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_acc_rd_sequencer.sv
// tb/tb_acc_rd_sequencer.sv - table-driven and randomized bench for acc_rd_sequencer
// Abort sequence is compiled in when ACC_RD_ABORT_EN is defined.
module tb_acc_rd_sequencer;

  localparam int MS = 32;
  localparam int AW = 7;
  localparam int NA = 1 << AW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            start_mode;
  logic [AW-1:0]   base_addr;
  logic [AW-1:0]   num_rows;
  logic            stall;
  logic            busy;
  logic            done;
  logic [MS-1:0]   rd_en;
  logic [MS*AW-1:0] rd_addr;
`ifdef ACC_RD_ABORT_EN
  logic            abort;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    bit         mode;
    int         base;
    int         rows;
    bit [255:0] pat;
    int         exp_issues;
    int         exp_done;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  acc_rd_sequencer #(.MUL_SIZE(MS), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_mode (start_mode),
    .base_addr  (base_addr),
    .num_rows   (num_rows),
    .stall      (stall),
`ifdef ACC_RD_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Lane view of one sweep step, straight from the sweep rules.
  function automatic void exp_step(input bit mode, input int base, input int rows, input int step,
                                   output logic [MS-1:0] en, output logic [MS*AW-1:0] addr);
    int r;
    int d;
    r    = (rows == 0) ? NA : rows;
    en   = '0;
    addr = '0;
    for (int c = 0; c < MS; c++) begin
      d = mode ? (step - c) : step;
      if (d >= 0 && d < r) begin
        en[c]            = 1'b1;
        addr[c*AW +: AW] = AW'((base + d) % NA);
      end
    end
  endfunction

  task automatic run_sweep(input bit mode, input int base, input int rows, input bit [255:0] pat,
                           input bit rnd, output int issues, output int done_cyc);
    int               total;
    int               issued;
    int               k;
    bit               stl;
    bit               fin;
    bit               in_done;
    logic [MS-1:0]    exp_en;
    logic [MS*AW-1:0] exp_addr;
    logic [MS*AW-1:0] prev;
    total      = mode ? (((rows == 0) ? NA : rows) + MS - 1) : ((rows == 0) ? NA : rows);
    issued     = 0;
    issues     = 0;
    done_cyc   = -1;
    fin        = 1'b0;
    in_done    = 1'b0;
    prev       = '0;
    start      = 1'b1;
    start_mode = mode;
    base_addr  = AW'(base);
    num_rows   = AW'(rows);
    stall      = pat[0] | (rnd && ($urandom % 4 == 0));
    stl        = stall;
    for (k = 1; k < 1000 && !fin; k++) begin
      @(negedge clk);
      if (rd_en != '0) issues++;
      if (done === 1'b1 && done_cyc < 0) done_cyc = k;
      if (in_done) begin
        chk("idle_busy", 256'(busy), 256'(0));
        chk("idle_done", 256'(done), 256'(0));
        chk("idle_rd_en", 256'(rd_en), 256'(0));
        fin = 1'b1;
      end else if (issued == total) begin
        chk("done_busy", 256'(busy), 256'(1));
        chk("done_pulse", 256'(done), 256'(1));
        chk("done_rd_en", 256'(rd_en), 256'(0));
        in_done = 1'b1;
      end else begin
        if (k > 1 && stl) begin
          exp_en   = '0;
          exp_addr = prev;
        end else begin
          exp_step(mode, base, rows, issued, exp_en, exp_addr);
          issued++;
        end
        prev = exp_addr;
        chk("run_busy", 256'(busy), 256'(1));
        chk("run_done", 256'(done), 256'(0));
        chk("run_rd_en", 256'(rd_en), 256'(exp_en));
        chk("run_rd_addr", 256'(rd_addr), 256'(exp_addr));
      end
      if (rnd) begin
        start      = 1'($urandom % 2);
        start_mode = 1'($urandom % 2);
        base_addr  = AW'($urandom % NA);
        num_rows   = AW'($urandom % NA);
      end else begin
        start = 1'b0;
      end
      stall = pat[k % 256] | (rnd && ($urandom % 4 == 0));
      stl   = stall;
    end
    if (!fin) begin
      n_chk++;
      $display("FAIL sweep_timeout: got no completion expected done within 1000 cycles");
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    int iss;
    int dc;
    int seen;
    vecs[0] = '{1'b0,   5, 3, 256'h0,  3,   4};
    vecs[1] = '{1'b1,   0, 2, 256'h0,  33,  34};
    vecs[2] = '{1'b0,  10, 4, 256'hC,  4,   7};
    vecs[3] = '{1'b0, 126, 0, 256'h0,  128, 129};
    vecs[4] = '{1'b1, 120, 5, 256'h0,  36,  37};
    vecs[5] = '{1'b0,   0, 1, 256'h1,  1,   2};
    vecs[6] = '{1'b1, 127, 1, 256'hE0, 32,  36};

    rst_n      = 1'b0;
    start      = 1'b0;
    start_mode = 1'b0;
    base_addr  = '0;
    num_rows   = '0;
    stall      = 1'b0;
`ifdef ACC_RD_ABORT_EN
    abort      = 1'b0;
`endif
    #1;
    chk("reset_busy", 256'(busy), 256'(0));
    chk("reset_done", 256'(done), 256'(0));
    chk("reset_rd_en", 256'(rd_en), 256'(0));
    chk("reset_rd_addr", 256'(rd_addr), 256'(0));

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run_sweep(vecs[i].mode, vecs[i].base, vecs[i].rows, vecs[i].pat, 1'b0, iss, dc);
      chk($sformatf("vec%0d_issues", i), 256'(iss), 256'(vecs[i].exp_issues));
      chk($sformatf("vec%0d_done_cycle", i), 256'(dc), 256'(vecs[i].exp_done));
    end

    for (int i = 0; i < 30; i++) begin
      int r;
      r = ($urandom % 6 == 0) ? 0 : int'($urandom % NA);
      run_sweep(1'($urandom % 2), int'($urandom % NA), r, 256'h0, 1'b1, iss, dc);
    end

    start      = 1'b1;
    start_mode = 1'b1;
    base_addr  = AW'(3);
    num_rows   = AW'(20);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrun_busy", 256'(busy), 256'(1));
    chk("midrun_lane0_addr", 256'(rd_addr[AW-1:0]), 256'(13));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rd_en", 256'(rd_en), 256'(0));
    chk("async_rst_rd_addr", 256'(rd_addr), 256'(0));
    chk("async_rst_busy", 256'(busy), 256'(0));
    chk("async_rst_done", 256'(done), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    chk("no_done_after_reset", 256'(seen), 256'(0));
    run_sweep(1'b1, 100, 40, 256'h0, 1'b0, iss, dc);
    chk("post_reset_issues", 256'(iss), 256'(71));

`ifdef ACC_RD_ABORT_EN
    abort = 1'b1;
    @(negedge clk);
    chk("abort_idle_busy", 256'(busy), 256'(0));
    abort      = 1'b0;
    start      = 1'b1;
    start_mode = 1'b0;
    base_addr  = AW'(0);
    num_rows   = AW'(8);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_step2_addr", 256'(rd_addr[AW-1:0]), 256'(2));
    abort = 1'b1;
    stall = 1'b1;
    @(negedge clk);
    chk("abort_rd_en", 256'(rd_en), 256'(0));
    chk("abort_done", 256'(done), 256'(1));
    abort = 1'b0;
    stall = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("abort_then_idle", 256'(busy), 256'(0));
    start = 1'b0;
    @(negedge clk);
    chk("abort_start_ignored", 256'(busy), 256'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
